// File: rtl/iter_shift_if.sv
// iter_shift_if: request/result bundle for iter_shift_ctrl.
// The master drives the request; the slave (the shifter) returns status and the result.
interface iter_shift_if #(
    parameter int DATA_WIDTH  = 64,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
);
    logic                   start;
    logic [1:0]             op;
    logic [DATA_WIDTH-1:0]  in_data;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic                   busy;
    logic                   done;
    logic [DATA_WIDTH-1:0]  out_data;

    modport master (output start, op, in_data, shamt, input busy, done, out_data);
    modport slave  (input start, op, in_data, shamt, output busy, done, out_data);
endinterface

// File: rtl/iter_shift_ctrl.sv
// iter_shift_ctrl: iterative LSL/LSR/ASR shifter moving two bits per cycle (one on an odd final step).
// Define ITER_SHIFT_ROR_EN to make op=11 a rotate-right; otherwise op=11 passes in_data through.
module iter_shift_ctrl #(
    parameter int DATA_WIDTH  = 64,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input logic         clk,
    input logic         reset_n,
    iter_shift_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [1:0] {LSL, LSR, ASR, ROR} op_t;

    state_t                 state, state_nx;
    op_t                    op_q;
    logic [DATA_WIDTH-1:0]  work, shifted;
    logic [SHAMT_WIDTH-1:0] rem, rem_nx;
    logic [1:0]             fill;
    logic                   two, accept, pass;

    assign accept = bus.start && state != SHIFT;
    assign two    = |rem[SHAMT_WIDTH-1:1];
    assign rem_nx = two ? rem - SHAMT_WIDTH'(2) : rem - SHAMT_WIDTH'(1);
`ifdef ITER_SHIFT_ROR_EN
    assign pass = 1'b0;
    // rotate: the bits leaving the LSB side re-enter at the top
    assign fill = op_q == ASR ? {2{work[DATA_WIDTH-1]}} : op_q == ROR ? work[1:0] : 2'b00;
`else
    assign pass = bus.op == 2'b11;
    assign fill = op_q == ASR ? {2{work[DATA_WIDTH-1]}} : 2'b00;
`endif

    always_comb begin
        shifted = op_q == LSL
            ? (two ? {work[DATA_WIDTH-3:0], 2'b00} : {work[DATA_WIDTH-2:0], 1'b0})
            : (two ? {fill, work[DATA_WIDTH-1:2]} : {fill[0], work[DATA_WIDTH-1:1]});
        state_nx = state;
        if (state == SHIFT)
            state_nx = rem_nx == '0 ? DONE : SHIFT;
        else if (!bus.start)
            state_nx = IDLE;
        else
            state_nx = (pass || bus.shamt == '0) ? DONE : SHIFT;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            op_q  <= LSL;
            rem   <= '0;
            work  <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                work <= bus.in_data;
                rem  <= pass ? '0 : bus.shamt;
                op_q <= op_t'(bus.op);
            end else if (state == SHIFT) begin
                work <= shifted;
                rem  <= rem_nx;
            end
        end
    end

    assign bus.busy     = state == SHIFT;
    assign bus.done     = state == DONE;
    assign bus.out_data = work;
endmodule

// File: tb/tb_iter_shift_ctrl.sv
// tb_iter_shift_ctrl: directed vectors checked by literals plus a cycle-indexed reference model.
module tb_iter_shift_ctrl;
    logic clk = 0;
    logic reset_n;
    int   tests = 0;
    int   fails = 0;

    iter_shift_if #(.DATA_WIDTH(64)) bus ();
    iter_shift_ctrl #(.DATA_WIDTH(64)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] f_res(input logic [1:0] o, input logic [63:0] d, input int k);
        case (o)
            2'd0: return d << k;
            2'd1: return d >> k;
            2'd2: return 64'($signed(d) >>> k);
`ifdef ITER_SHIFT_ROR_EN
            default: return k == 0 ? d : (d >> k) | (d << (64 - k));
`else
            default: return d;
`endif
        endcase
    endfunction

    function automatic int f_lat(input logic [1:0] o, input int k);
`ifndef ITER_SHIFT_ROR_EN
        if (o == 2'd3) return 0;
`endif
        return (k + 1) / 2;
    endfunction

    // Model: a request accepted at edge a is busy after edges a..a+L-1 and done after edge a+L.
    int          cyc = 0;
    int          a = 0;
    int          lat = 0;
    logic        have = 0;
    logic [63:0] res = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            have <= 0;
        end else begin
            cyc <= cyc + 1;
            if (bus.start && (!have || cyc >= a + lat)) begin
                have <= 1;
                a    <= cyc + 1;
                lat  <= f_lat(bus.op, int'(bus.shamt));
                res  <= f_res(bus.op, bus.in_data, int'(bus.shamt));
            end
        end
    end

    always @(negedge clk) begin
        check("model_busy", 64'(bus.busy), 64'(have && cyc >= a && cyc < a + lat));
        check("model_done", 64'(bus.done), 64'(have && cyc == a + lat));
        if (!have)
            check("model_out_reset", bus.out_data, 64'h0);
        else if (cyc >= a + lat)
            check("model_out", bus.out_data, res);
    end

    task automatic wait_done(output int n, output int b);
        n = 0;
        b = 0;
        do begin
            @(negedge clk);
            bus.start = 0;
            n++;
            if (bus.busy) b++;
        end while (!bus.done && n < 100);
        check("done_seen", 64'(bus.done), 64'h1);
    endtask

    task automatic issue(input logic [1:0] o, input logic [63:0] d, input int k);
        bus.op      = o;
        bus.in_data = d;
        bus.shamt   = 6'(k);
        bus.start   = 1;
        @(posedge clk);
    endtask

    task automatic run(input string nm, input logic [1:0] o, input logic [63:0] d, input int k,
                       input logic [63:0] eo, input int el, input int eb);
        int n, b;
        issue(o, d, k);
        wait_done(n, b);
        check({nm, "_out"}, bus.out_data, eo);
        check({nm, "_lat"}, 64'(n), 64'(el));
        check({nm, "_busy"}, 64'(b), 64'(eb));
    endtask

    initial begin
        int n, b;
        reset_n     = 0;
        bus.start   = 0;
        bus.op      = 0;
        bus.in_data = 0;
        bus.shamt   = 0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'h0);
        check("rst_done", 64'(bus.done), 64'h0);
        check("rst_out", bus.out_data, 64'h0);
        reset_n = 1;
        @(negedge clk);

        run("lsl5", 2'd0, 64'h1, 5, 64'h20, 4, 3);
        @(negedge clk);
        run("asr63", 2'd2, 64'h8000_0000_0000_0000, 63, 64'hFFFF_FFFF_FFFF_FFFF, 33, 32);
        run("lsr63", 2'd1, 64'h8000_0000_0000_0000, 63, 64'h1, 33, 32);
        run("lsr0", 2'd1, 64'hDEAD_BEEF, 0, 64'hDEAD_BEEF, 1, 0);
        run("asr4", 2'd2, 64'h8000_0000_0000_00F0, 4, 64'hF800_0000_0000_000F, 3, 2);
        run("lsr3", 2'd1, 64'hF0, 3, 64'h1E, 3, 2);
        run("lsl7", 2'd0, 64'hFF, 7, 64'h7F80, 5, 4);
        @(negedge clk);

        // start during busy must be ignored; start during done is taken back-to-back
        issue(2'd0, 64'h3, 4);
        @(negedge clk);
        bus.in_data = 64'hFFFF;
        bus.shamt   = 6'd7;
        @(posedge clk);
        wait_done(n, b);
        check("ign_out", bus.out_data, 64'h30);
        check("ign_lat", 64'(n), 64'h2);
        run("b2b", 2'd1, 64'h30, 4, 64'h3, 3, 2);
        @(negedge clk);

        issue(2'd0, 64'h1, 40);
        @(negedge clk);
        bus.start = 0;
        repeat (4) @(negedge clk);
        #2 reset_n = 0;
        #1;
        check("abort_busy", 64'(bus.busy), 64'h0);
        check("abort_done", 64'(bus.done), 64'h0);
        check("abort_out", bus.out_data, 64'h0);
        repeat (2) @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        run("post_rst", 2'd0, 64'h1, 2, 64'h4, 2, 1);

`ifdef ITER_SHIFT_ROR_EN
        run("ror1", 2'd3, 64'h1, 1, 64'h8000_0000_0000_0000, 2, 1);
        run("ror8", 2'd3, 64'h1234, 8, 64'h3400_0000_0000_0012, 5, 4);
`else
        run("pass1", 2'd3, 64'h1, 1, 64'h1, 1, 0);
        run("pass8", 2'd3, 64'h1234, 8, 64'h1234, 1, 0);
`endif
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
